// File: rtl/decode_format_queue_if.sv
// decode_format_queue_if: fetch-group input and tagged single-instruction output bundle
interface decode_format_queue_if #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int FetchWidth              = 4,
    parameter int QueueDepth              = 8,
    parameter int formatWidth             = 5
);
    localparam int CountWidth = $clog2(FetchWidth + 1);
    localparam int OccWidth   = $clog2(QueueDepth + 1);
    logic                                   enable_i;
    logic                                   stall_i;
    logic                                   flush_i;
    logic                                   fetchValid_i;
    logic [CountWidth-1:0]                  fetchCount_i;
    logic [FetchWidth*instructionWidth-1:0] instructions_i;
    logic [addressWidth-1:0]                instructionAddress_i;
    logic [PidSize-1:0]                     instructionPid_i;
    logic [TidSize-1:0]                     instructionTid_i;
    logic [instructionCounterWidth-1:0]     instructionMajId_i;
    logic                                   fetchReady_o;
    logic                                   valid_o;
    logic [instructionWidth-1:0]            instruction_o;
    logic [addressWidth-1:0]                instructionAddress_o;
    logic [PidSize-1:0]                     instructionPid_o;
    logic [TidSize-1:0]                     instructionTid_o;
    logic [instructionCounterWidth-1:0]     instructionMajId_o;
    logic [5:0]                             opcode_o;
    logic [formatWidth-1:0]                 format_o;
    logic [OccWidth-1:0]                    occupancy_o;
    modport master (
        output enable_i, stall_i, flush_i, fetchValid_i, fetchCount_i, instructions_i,
               instructionAddress_i, instructionPid_i, instructionTid_i, instructionMajId_i,
        input  fetchReady_o, valid_o, instruction_o, instructionAddress_o, instructionPid_o,
               instructionTid_o, instructionMajId_o, opcode_o, format_o, occupancy_o
    );
    modport slave (
        input  enable_i, stall_i, flush_i, fetchValid_i, fetchCount_i, instructions_i,
               instructionAddress_i, instructionPid_i, instructionTid_i, instructionMajId_i,
        output fetchReady_o, valid_o, instruction_o, instructionAddress_o, instructionPid_o,
               instructionTid_o, instructionMajId_o, opcode_o, format_o, occupancy_o
    );
endinterface

// File: rtl/decode_format_queue.sv
// decode_format_queue: buffers multi-lane fetch groups and issues one format-tagged instruction per cycle
module decode_format_queue #(
    parameter int addressWidth            = 64,
    parameter int instructionWidth        = 32,
    parameter int PidSize                 = 20,
    parameter int TidSize                 = 16,
    parameter int instructionCounterWidth = 64,
    parameter int FetchWidth              = 4,
    parameter int QueueDepth              = 8,
    parameter int formatWidth             = 5
) (
    input logic                  clock_i,
    input logic                  reset_i,
    decode_format_queue_if.slave bus
);
    localparam int CountWidth = $clog2(FetchWidth + 1);
    localparam int OccWidth   = $clog2(QueueDepth + 1);
    localparam int PtrWidth   = $clog2(QueueDepth);
    logic [instructionWidth-1:0]        mem_ins [QueueDepth];
    logic [addressWidth-1:0]            mem_addr[QueueDepth];
    logic [PidSize-1:0]                 mem_pid [QueueDepth];
    logic [TidSize-1:0]                 mem_tid [QueueDepth];
    logic [instructionCounterWidth-1:0] mem_maj [QueueDepth];
    logic [PtrWidth-1:0]                rd_ptr, wr_ptr;
    logic [OccWidth-1:0]                occ;
    logic [CountWidth-1:0]              cnt;
    logic                               push, pop, drain;
    logic [5:0]                         head_op;
    logic [formatWidth-1:0]             head_fmt;
    assign bus.fetchReady_o = !bus.flush_i && (int'(occ) <= QueueDepth - FetchWidth);
    assign bus.occupancy_o  = occ;
    always_comb begin
        cnt   = (int'(bus.fetchCount_i) > FetchWidth) ? CountWidth'(FetchWidth) : bus.fetchCount_i;
        push  = bus.enable_i && bus.fetchValid_i && bus.fetchReady_o && cnt != '0;
        pop   = bus.enable_i && !bus.flush_i && occ != '0 && (!bus.valid_o || !bus.stall_i);
        drain = bus.enable_i && !bus.flush_i && occ == '0 && bus.valid_o && !bus.stall_i;
    end
    // Power bit numbering: primary opcode bits 0:5 are the most significant six bits
    assign head_op = mem_ins[rd_ptr][instructionWidth-1 -: 6];
    always_comb begin
        head_fmt = '0;
        case (head_op)
            6'd18:        head_fmt = formatWidth'(1);
            6'd16:        head_fmt = formatWidth'(2);
            6'd17:        head_fmt = formatWidth'(3);
            6'd31:        head_fmt = formatWidth'(4);
            6'd19:        head_fmt = formatWidth'(5);
            6'd30:        head_fmt = formatWidth'(6);
            6'd58, 6'd62: head_fmt = formatWidth'(7);
            6'd59, 6'd63: head_fmt = formatWidth'(8);
            6'd4:         head_fmt = formatWidth'(9);
            6'd0:         head_fmt = formatWidth'(31);
            default:      head_fmt = '0;
        endcase
    end
    always_ff @(posedge clock_i)
        for (int k = 0; k < FetchWidth; k++)
            if (push && k < int'(cnt)) begin
                mem_ins [wr_ptr + PtrWidth'(k)] <= bus.instructions_i[k*instructionWidth +: instructionWidth];
                mem_addr[wr_ptr + PtrWidth'(k)] <= bus.instructionAddress_i + addressWidth'(4 * k);
                mem_pid [wr_ptr + PtrWidth'(k)] <= bus.instructionPid_i;
                mem_tid [wr_ptr + PtrWidth'(k)] <= bus.instructionTid_i;
                mem_maj [wr_ptr + PtrWidth'(k)] <= bus.instructionMajId_i + instructionCounterWidth'(k);
            end
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr                   <= '0;
            wr_ptr                   <= '0;
            occ                      <= '0;
            bus.valid_o              <= 1'b0;
            bus.instruction_o        <= '0;
            bus.instructionAddress_o <= '0;
            bus.instructionPid_o     <= '0;
            bus.instructionTid_o     <= '0;
            bus.instructionMajId_o   <= '0;
            bus.opcode_o             <= '0;
            bus.format_o             <= '0;
        end else if (bus.flush_i) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            occ         <= '0;
            bus.valid_o <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PtrWidth'(cnt);
            if (pop) begin
                rd_ptr                   <= rd_ptr + PtrWidth'(1);
                bus.valid_o              <= 1'b1;
                bus.instruction_o        <= mem_ins[rd_ptr];
                bus.instructionAddress_o <= mem_addr[rd_ptr];
                bus.instructionPid_o     <= mem_pid[rd_ptr];
                bus.instructionTid_o     <= mem_tid[rd_ptr];
                bus.instructionMajId_o   <= mem_maj[rd_ptr];
                bus.opcode_o             <= head_op;
                bus.format_o             <= head_fmt;
            end else if (drain) begin
                bus.valid_o <= 1'b0;
            end
            occ <= occ + (push ? OccWidth'(cnt) : '0) - (pop ? OccWidth'(1) : '0);
        end
    end
endmodule

// File: tb/tb_decode_format_queue.sv
// tb_decode_format_queue: random and directed stimulus against a queue-based reference with an output scoreboard
module tb_decode_format_queue;
    localparam int AW = 64, IW = 32, PS = 20, TS = 16, MW = 64, FW = 4, QD = 8, FMW = 5;
    localparam int NW = $clog2(FW + 1);
    typedef struct {
        logic [IW-1:0] ins;
        logic [AW-1:0] addr;
        logic [PS-1:0] pid;
        logic [TS-1:0] tid;
        logic [MW-1:0] maj;
    } ent_t;
    logic clock_i = 1'b0;
    logic reset_i = 1'b0;
    int   errors  = 0;
    int   checks  = 0;
    ent_t pending[$];
    ent_t sb[$];
    logic exp_valid = 1'b0;
    always #5 clock_i = ~clock_i;
    decode_format_queue_if #(.addressWidth(AW), .instructionWidth(IW), .PidSize(PS), .TidSize(TS),
        .instructionCounterWidth(MW), .FetchWidth(FW), .QueueDepth(QD), .formatWidth(FMW)) bus ();
    decode_format_queue #(.addressWidth(AW), .instructionWidth(IW), .PidSize(PS), .TidSize(TS),
        .instructionCounterWidth(MW), .FetchWidth(FW), .QueueDepth(QD), .formatWidth(FMW)) dut (
        .clock_i(clock_i), .reset_i(reset_i), .bus(bus));
    function automatic logic [FMW-1:0] fmt_of(input logic [5:0] op);
        case (op)
            18: return 1;
            16: return 2;
            17: return 3;
            31: return 4;
            19: return 5;
            30: return 6;
            58, 62: return 7;
            59, 63: return 8;
            4: return 9;
            0: return 31;
            default: return 0;
        endcase
    endfunction
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask
    // Reference: the DUT queue is a list of pending entries; an entry moves to the scoreboard when the output loads
    always @(negedge clock_i) begin
        if (!reset_i) begin
            pending.delete();
            sb.delete();
            exp_valid = 1'b0;
        end else begin
            automatic int   occ = pending.size();
            automatic logic rdy = !bus.flush_i && (QD - occ >= FW);
            automatic int   c   = (int'(bus.fetchCount_i) > FW) ? FW : int'(bus.fetchCount_i);
            automatic ent_t e;
            check("fetch_ready", 128'(bus.fetchReady_o), 128'(rdy));
            check("occupancy", 128'(bus.occupancy_o), 128'(occ));
            check("valid", 128'(bus.valid_o), 128'(exp_valid));
            if (bus.flush_i) begin
                pending.delete();
                exp_valid = 1'b0;
            end else if (bus.enable_i) begin
                if (occ != 0 && (!exp_valid || !bus.stall_i)) begin
                    sb.push_back(pending.pop_front());
                    exp_valid = 1'b1;
                end else if (exp_valid && !bus.stall_i) begin
                    exp_valid = 1'b0;
                end
                if (bus.fetchValid_i && rdy)
                    for (int k = 0; k < c; k++) begin
                        e.ins  = bus.instructions_i[k*IW +: IW];
                        e.addr = bus.instructionAddress_i + AW'(4 * k);
                        e.pid  = bus.instructionPid_i;
                        e.tid  = bus.instructionTid_i;
                        e.maj  = bus.instructionMajId_i + MW'(k);
                        pending.push_back(e);
                    end
            end
        end
    end
    logic          last_v = 1'b0, last_take = 1'b0;
    logic [IW-1:0] h_ins;
    logic [AW-1:0] h_addr;
    logic [MW-1:0] h_maj;
    logic [5:0]    h_op;
    logic [FMW-1:0] h_fmt;
    always @(negedge clock_i) begin
        if (!reset_i) begin
            last_v    = 1'b0;
            last_take = 1'b0;
        end else begin
            if (bus.valid_o) begin
                if (!last_v || last_take) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output: actual=valid instr %0h required=no output", bus.instruction_o);
                    end else begin
                        automatic ent_t e = sb.pop_front();
                        check("instruction", 128'(bus.instruction_o), 128'(e.ins));
                        check("address", 128'(bus.instructionAddress_o), 128'(e.addr));
                        check("pid", 128'(bus.instructionPid_o), 128'(e.pid));
                        check("tid", 128'(bus.instructionTid_o), 128'(e.tid));
                        check("majid", 128'(bus.instructionMajId_o), 128'(e.maj));
                        check("opcode", 128'(bus.opcode_o), 128'(e.ins[IW-1 -: 6]));
                        check("format", 128'(bus.format_o), 128'(fmt_of(e.ins[IW-1 -: 6])));
                    end
                end else begin
                    check("hold_instruction", 128'(bus.instruction_o), 128'(h_ins));
                    check("hold_address", 128'(bus.instructionAddress_o), 128'(h_addr));
                    check("hold_majid", 128'(bus.instructionMajId_o), 128'(h_maj));
                    check("hold_opcode", 128'(bus.opcode_o), 128'(h_op));
                    check("hold_format", 128'(bus.format_o), 128'(h_fmt));
                end
                h_ins  = bus.instruction_o;
                h_addr = bus.instructionAddress_o;
                h_maj  = bus.instructionMajId_o;
                h_op   = bus.opcode_o;
                h_fmt  = bus.format_o;
            end
            last_v    = bus.valid_o;
            last_take = bus.valid_o && bus.enable_i && !bus.stall_i;
        end
    end
    task automatic step();
        @(posedge clock_i);
        #1;
    endtask
    task automatic set_lanes(input logic [6*FW-1:0] ops);
        for (int k = 0; k < FW; k++) bus.instructions_i[k*IW +: IW] = {ops[k*6 +: 6], 26'($urandom)};
    endtask
    task automatic drive(input int cnt, input logic [AW-1:0] a, input logic [MW-1:0] m, input logic [6*FW-1:0] ops);
        bus.fetchValid_i         = 1'b1;
        bus.fetchCount_i         = NW'(cnt);
        bus.instructionAddress_i = a;
        bus.instructionMajId_i   = m;
        bus.instructionPid_i     = PS'($urandom);
        bus.instructionTid_i     = TS'($urandom);
        set_lanes(ops);
        step();
        bus.fetchValid_i = 1'b0;
    endtask
    initial begin
        bus.enable_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.fetchValid_i = 1'b0;
        bus.fetchCount_i = '0;
        bus.instructions_i = '0;
        bus.instructionAddress_i = '0;
        bus.instructionPid_i = '0;
        bus.instructionTid_i = '0;
        bus.instructionMajId_i = '0;
        repeat (3) step();
        reset_i = 1'b1;
        step();
        drive(4, 64'h1000, 64'd10, {6'd14, 6'd16, 6'd31, 6'd18});
        repeat (6) step();
        bus.stall_i = 1'b1;
        drive(4, 64'h2000, 64'd100, {6'd1, 6'd2, 6'd3, 6'd4});
        drive(4, 64'h3000, 64'd200, {6'd5, 6'd6, 6'd7, 6'd8});
        drive(4, 64'h4000, 64'd300, {6'd9, 6'd10, 6'd11, 6'd12});
        repeat (2) step();
        bus.stall_i = 1'b0;
        repeat (12) step();
        drive(2, 64'hFFFF_FFFF_FFFF_FFFC, '1, {6'd0, 6'd0, 6'd31, 6'd18});
        repeat (4) step();
        drive(4, 64'h5000, 64'd50, {6'd18, 6'd18, 6'd18, 6'd18});
        bus.flush_i = 1'b1;
        bus.fetchValid_i = 1'b1;
        bus.fetchCount_i = NW'(4);
        set_lanes({6'd16, 6'd16, 6'd16, 6'd16});
        step();
        bus.flush_i = 1'b0;
        bus.fetchValid_i = 1'b0;
        repeat (3) step();
        drive(4, 64'h6000, 64'd60, {6'd59, 6'd62, 6'd58, 6'd0});
        drive(4, 64'h7000, 64'd70, {6'd19, 6'd17, 6'd4, 6'd63});
        repeat (4) step();
        drive(7, 64'h8000, 64'd80, {6'd40, 6'd41, 6'd42, 6'd30});
        repeat (8) step();
        for (int i = 0; i < 400; i++) begin
            bus.enable_i = ($urandom_range(0, 9) != 0);
            bus.stall_i = ($urandom_range(0, 2) == 0);
            bus.flush_i = ($urandom_range(0, 39) == 0);
            bus.fetchValid_i = 1'($urandom);
            bus.fetchCount_i = NW'($urandom_range(0, 7));
            bus.instructionAddress_i = {$urandom, $urandom};
            bus.instructionMajId_i = {$urandom, $urandom};
            bus.instructionPid_i = PS'($urandom);
            bus.instructionTid_i = TS'($urandom);
            for (int k = 0; k < FW; k++) bus.instructions_i[k*IW +: IW] = $urandom;
            step();
        end
        bus.enable_i = 1'b1;
        bus.stall_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.fetchValid_i = 1'b0;
        repeat (15) step();
        bus.stall_i = 1'b1;
        drive(4, 64'h9000, 64'd90, {6'd1, 6'd2, 6'd3, 6'd4});
        drive(2, 64'hA000, 64'd95, {6'd5, 6'd6, 6'd7, 6'd8});
        check("occupancy_before_reset", 128'(bus.occupancy_o), 128'd5);
        #2;
        reset_i = 1'b0;
        #1;
        check("async_reset_valid", 128'(bus.valid_o), 128'd0);
        check("async_reset_occupancy", 128'(bus.occupancy_o), 128'd0);
        check("async_reset_instruction", 128'(bus.instruction_o), 128'd0);
        check("async_reset_address", 128'(bus.instructionAddress_o), 128'd0);
        check("async_reset_majid", 128'(bus.instructionMajId_o), 128'd0);
        check("async_reset_format", 128'(bus.format_o), 128'd0);
        repeat (2) step();
        reset_i = 1'b1;
        bus.stall_i = 1'b0;
        step();
        check("ready_after_reset", 128'(bus.fetchReady_o), 128'd1);
        repeat (10) step();
        check("scoreboard_drained", 128'(sb.size()), 128'd0);
        check("reference_drained", 128'(pending.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/decode_format_queue.md
Name: decode_format_queue

Overview:
- Parametrised successor to decode stage 1 (format decode).
- Accepts a multi-lane fetch group (up to FetchWidth instructions per cycle) with shared PID/TID, base address and base major ID, and buffers the instructions in a circular queue.
- Each cycle it issues one instruction to stage 2 (format-specific decode), tagged with its primary opcode and format class.
- Adds per-lane address/ID generation, backpressure, stall and flush support.

Parameters:
- addressWidth, 64, instruction address width.
- instructionWidth, 32, instruction width (fixed 4 bytes).
- PidSize, 20, process ID width.
- TidSize, 16, thread ID width.
- instructionCounterWidth, 64, major ID width.
- FetchWidth, 4, lanes per fetch group (1..8).
- QueueDepth, 8, queue entries (power of 2, >= FetchWidth).
- formatWidth, 5, format code width (covers 25 ISA formats).

Ports:
- clock_i  in  1  clock; all flops on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  block enable; low freezes push and pop.
- stall_i  in  1  stage 2 cannot take the output this cycle.
- flush_i  in  1  synchronous flush of all buffered instructions.
- fetchValid_i  in  1  fetch group present.
- fetchCount_i  in  $clog2(FetchWidth+1)  number of valid lanes; valid lanes are contiguous from lane 0.
- instructions_i  in  FetchWidth*instructionWidth  lane k occupies bits [k*instructionWidth : k*instructionWidth+instructionWidth-1].
- instructionAddress_i  in  addressWidth  address of lane 0.
- instructionPid_i  in  PidSize  PID for the group.
- instructionTid_i  in  TidSize  TID for the group.
- instructionMajId_i  in  instructionCounterWidth  major ID of lane 0.
- fetchReady_o  out  1  queue can accept a full group.
- valid_o  out  1  output register holds an instruction.
- instruction_o  out  instructionWidth  instruction word.
- instructionAddress_o  out  addressWidth  instruction address.
- instructionPid_o  out  PidSize  PID.
- instructionTid_o  out  TidSize  TID.
- instructionMajId_o  out  instructionCounterWidth  major ID.
- opcode_o  out  6  primary opcode (instruction bits 0:5).
- format_o  out  formatWidth  format class.
- occupancy_o  out  $clog2(QueueDepth+1)  number of queue entries (output register excluded).

Behaviour:
- Reset (reset_i=0, async): pointers and occupancy cleared to 0; valid_o=0; all data outputs, opcode_o and format_o = 0. fetchReady_o=1 once reset is released.
- fetchReady_o = !flush_i && (QueueDepth - occupancy >= FetchWidth). It is computed from the pre-pop count, so it never relies on a same-cycle pop.
- Push:
  - Occurs when enable_i && fetchValid_i && fetchReady_o && !flush_i && fetchCount_i != 0.
  - fetchCount_i > FetchWidth is clamped to FetchWidth.
  - Lanes 0..count-1 are written in lane order.
  - Entry k gets address = instructionAddress_i + 4k and MajId = instructionMajId_i + k. Both wrap modulo 2^width.
  - PID and TID are copied to every entry.
- Pop:
  - The output register loads the queue head when enable_i && occupancy != 0 && (!valid_o || !stall_i).
  - If the output is consumed (valid_o && !stall_i && enable_i) while the queue is empty, valid_o clears next edge.
  - While stall_i=1 and valid_o=1, every output holds stable.
- Latency:
  - A group pushed at edge N has lane 0 on the outputs after edge N+1 (queue empty, no stall).
  - Subsequent lanes follow one per cycle.
  - No bypass from input to output.
- Simultaneous push and pop in the same cycle: occupancy' = occupancy + count - 1.
- Pointers wrap modulo QueueDepth.
- Classification is combinational on the head opcode and registered with the entry (op = bits 0:5):
  - 18 -> 1 (I); 16 -> 2 (B); 17 -> 3 (SC); 31 -> 4 (X/XO); 19 -> 5 (XL); 30 -> 6 (MD).
  - 58 or 62 -> 7 (DS); 59 or 63 -> 8 (A/X-FP); 4 -> 9 (VA/VX).
  - 0 -> 31 (illegal).
  - All other opcodes -> 0 (D).
- Flush:
  - Highest priority; acts regardless of enable_i.
  - At the next edge occupancy=0, pointers=0, valid_o=0.
  - Any same-cycle fetch group is discarded.
- enable_i=0 with flush_i=0: no state change, and outputs hold.
- Reset asserted mid-operation: immediate clear, with buffered instructions lost.
- Order is strictly FIFO. An entry is never issued twice and never dropped except by flush or reset.

Test Plan:
- Reset, then push count=4 at addr 0x1000, MajId 10, ops {18,31,16,14} -> outputs on 4 consecutive cycles: addr 0x1000/0x1004/0x1008/0x100C, MajId 10..13, format 1,4,2,0; then valid_o=0.
- Push two count=4 groups with stall_i held high -> occupancy_o=7 (1 entry in output reg), fetchReady_o=0, third group ignored; release stall -> 8 ordered outputs.
- count=2, addr 0xFFFF_FFFF_FFFF_FFFC, MajId 2^64-1 -> second entry addr 0x0, MajId 0.
- Push group, flush_i the cycle after while fetchValid_i=1 -> next edge valid_o=0, occupancy_o=0, new group not stored.
- Opcode 0 and opcodes 58/62/59/63/4/17/19/30 -> format_o 31,7,7,8,8,9,3,5,6.
- Drop reset_i mid-stream with occupancy 5 -> outputs zero asynchronously; after release, fetchReady_o=1 and occupancy_o=0.
